// File: rtl/ram_dump_tx_pkg.sv
// ram_dump_tx_pkg
// Shared definitions for the RAM dump transmitter:
//   - dump_state_e   : states of the dump sequencer in ram_dump_tx
//   - calc_baud_div  : clock cycles per UART bit for a given clock and baud rate
package ram_dump_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } dump_state_e;

  // Integer division; the caller must keep the result >= 2.
  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/ram_dump_tx_uart.sv
// uart_tx_byte
// 8N1 byte transmitter with its own baud and bit counters.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   synchronous active-low reset
//   valid_i  in   byte offered
//   data_i   in   byte to send, LSB first
//   ready_o  out  byte accepted when valid_i && ready_o
//   tx_o     out  serial line, idles high
module uart_tx_byte
  import ram_dump_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0] STOP_BIT_IDX = 4'd9;

  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic [8:0]       shift_q, shift_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             bit_end;
  logic             frame_end;
  logic             accept;

  // ready_o also rises during the last cycle of the stop bit, so a byte
  // offered then starts its start bit on the very next cycle and frames abut.
  assign bit_end   = busy_q && (baud_cnt_q == BAUD_LAST);
  assign frame_end = bit_end && (bit_cnt_q == STOP_BIT_IDX);
  assign ready_o   = !busy_q || frame_end;
  assign accept    = valid_i && ready_o;
  assign tx_o      = tx_q;

  // Next-state for the bit sequencer. shift holds the 8 data bits with the
  // stop bit on top; the start bit is driven directly on accept.
  always_comb begin
    busy_d     = busy_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (accept) begin
      busy_d     = 1'b1;
      tx_d       = 1'b0;
      shift_d    = {1'b1, data_i};
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (frame_end) begin
      busy_d     = 1'b0;
      tx_d       = 1'b1;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_end) begin
      baud_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + 4'd1;
      tx_d       = shift_q[0];
      shift_d    = {1'b1, shift_q[8:1]};
    end else if (busy_q) begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end
  end

  // Register stage; reset returns the line high on the next edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/ram_dump_tx.sv
// ram_dump_tx
// Reads 32-bit words from the line-wide main RAM and streams them over a
// UART (8N1), least significant byte first, then one XOR checksum byte.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i                one-cycle dump request (only seen in IDLE)
//   start_addr_i           first word address
//   word_cnt_i             words to send, 0..RAM_DEPTH
//   busy_o, done_o         dump in progress / one-cycle completion pulse
//   mem_gnt_i              RAM read port granted to this block
//   mem_rd_en_o            RAM read enable
//   mem_addr_o             current word address
//   mem_rdata_i            line data, valid one cycle after mem_rd_en_o
//   uart_tx_o              serial output, idles high
module ram_dump_tx
  import ram_dump_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ         = 50_000_000,
  parameter int unsigned BAUD_RATE        = 115_200,
  parameter int unsigned CACHE_LINE_WIDTH = 128,
  parameter int unsigned RAM_DEPTH        = 32768
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [$clog2(RAM_DEPTH)-1:0]  start_addr_i,
  input  logic [$clog2(RAM_DEPTH):0]    word_cnt_i,
  output logic                          busy_o,
  output logic                          done_o,
  input  logic                          mem_gnt_i,
  output logic                          mem_rd_en_o,
  output logic [$clog2(RAM_DEPTH)-1:0]  mem_addr_o,
  input  logic [CACHE_LINE_WIDTH-1:0]   mem_rdata_i,
  output logic                          uart_tx_o
);

  localparam int unsigned AW             = $clog2(RAM_DEPTH);
  localparam int unsigned CW             = AW + 1;
  localparam int unsigned WORDS_PER_LINE = CACHE_LINE_WIDTH / 32;
  // byte_idx value meaning all four bytes of the word have been handed off
  localparam logic [2:0]  ALL_BYTES_SENT = 3'd4;

  dump_state_e     state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic [31:0]     word_q, word_d;
  logic [7:0]      csum_q, csum_d;
  logic [2:0]      byte_idx_q, byte_idx_d;

  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic [31:0]     line_word;
  int unsigned     word_off;

  assign word_off    = 32'(addr_q) % WORDS_PER_LINE;
  assign mem_addr_o  = addr_q;
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o      = (state_q == ST_DONE);
  assign mem_rd_en_o = (state_q == ST_REQ) && mem_gnt_i;

  // Pick the addressed 32-bit word out of the returned line.
  always_comb begin
    line_word = mem_rdata_i[31:0];
    for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
      if (word_off == i) begin
        line_word = mem_rdata_i[i*32 +: 32];
      end
    end
  end

  // Dump sequencer. In SEND the word register shifts right one byte per
  // handoff so the outgoing byte is always word_q[7:0]. When the final word
  // finishes, the checksum is offered in the same cycle so it abuts byte 3;
  // CSUM then just waits for that frame to end.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    csum_d      = csum_q;
    byte_idx_d  = byte_idx_q;
    tx_valid    = 1'b0;
    tx_data     = word_q[7:0];
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d      = start_addr_i;
          remaining_d = word_cnt_i;
          csum_d      = 8'h00;
          state_d     = (word_cnt_i == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        word_d     = line_word;
        byte_idx_d = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (byte_idx_q != ALL_BYTES_SENT) begin
            tx_valid   = 1'b1;
            tx_data    = word_q[7:0];
            csum_d     = csum_q ^ word_q[7:0];
            word_d     = {8'h00, word_q[31:8]};
            byte_idx_d = byte_idx_q + 3'd1;
          end else begin
            remaining_d = remaining_q - CW'(1);
            addr_d      = addr_q + AW'(1);
            if (remaining_q == CW'(1)) begin
              tx_valid = 1'b1;
              tx_data  = csum_q;
              state_d  = ST_CSUM;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_CSUM: begin
        if (tx_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      byte_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      byte_idx_q  <= byte_idx_d;
    end
  end

  uart_tx_byte #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_uart_tx (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (tx_valid),
    .data_i  (tx_data),
    .ready_o (tx_ready),
    .tx_o    (uart_tx_o)
  );

endmodule

// File: tb/tb_ram_dump_tx.sv
// tb_ram_dump_tx
// Scoreboard bench: each dump request pushes the expected read addresses and
// UART bytes (computed from a word-array RAM image); independent monitors
// decode the serial line and watch the RAM port, popping and comparing.
module tb_ram_dump_tx;

  localparam int unsigned CLK_FREQ     = 1_000_000;
  localparam int unsigned BAUD_RATE    = 100_000;
  localparam int unsigned BAUD_DIV     = 10;
  localparam int unsigned FRAME_CYCLES = 10 * BAUD_DIV;
  localparam int unsigned LINE_W       = 128;
  localparam int unsigned WPL          = LINE_W / 32;
  localparam int unsigned RAM_DEPTH    = 32768;
  localparam int unsigned AW           = 15;

  logic              clk = 1'b0;
  logic              rstN;
  logic              start;
  logic [AW-1:0]     startAddr;
  logic [AW:0]       wordCnt;
  logic              busy;
  logic              done;
  logic              gnt;
  logic              rdEn;
  logic [AW-1:0]     memAddr;
  logic [LINE_W-1:0] rdata;
  logic              tx;

  // gapKind: 0 = first byte of a dump, 1 = must abut previous frame,
  //          2 = first byte of a later word (needs the fetch gap)
  typedef struct packed {
    logic [7:0] data;
    logic [1:0] gapKind;
  } expByte_t;

  expByte_t    expByteQ[$];
  int unsigned expAddrQ[$];
  logic [31:0] memModel [RAM_DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cycleCount = 0;
  int          doneCount = 0;
  bit          ignoreRx = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  ram_dump_tx #(
    .CLK_FREQ         (CLK_FREQ),
    .BAUD_RATE        (BAUD_RATE),
    .CACHE_LINE_WIDTH (LINE_W),
    .RAM_DEPTH        (RAM_DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .start_i      (start),
    .start_addr_i (startAddr),
    .word_cnt_i   (wordCnt),
    .busy_o       (busy),
    .done_o       (done),
    .mem_gnt_i    (gnt),
    .mem_rd_en_o  (rdEn),
    .mem_addr_o   (memAddr),
    .mem_rdata_i  (rdata),
    .uart_tx_o    (tx)
  );

  // Registered line-wide RAM; garbage on the bus when not reading.
  always @(posedge clk) begin
    if (rdEn) begin
      for (int k = 0; k < int'(WPL); k++) begin
        rdata[k*32 +: 32] <= memModel[(int'(memAddr) / WPL) * WPL + k];
      end
    end else begin
      rdata <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // RAM port and done monitor.
  always @(negedge clk) begin
    if (rstN === 1'b1 && rdEn === 1'b1) begin
      checkOutput("rdEnOnlyWithGnt", 32'(gnt), 32'd1);
      if (expAddrQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rdUnexpected: got read at 0x%0h, expected none", memAddr);
      end else begin
        checkOutput("rdAddr", 32'(memAddr), expAddrQ.pop_front());
      end
    end
    if (rstN === 1'b1 && done === 1'b1) begin
      doneCount++;
      checkOutput("busyLowAtDone", 32'(busy), 32'd0);
    end
  end

  // UART decoder: samples each bit at its middle.
  initial begin : uartMonitor
    logic     prevTx;
    logic [9:0] frame;
    int       startCycle;
    int       lastStart;
    expByte_t e;
    prevTx    = 1'b1;
    lastStart = 0;
    forever begin
      @(negedge clk);
      if (rstN === 1'b1 && prevTx === 1'b1 && tx === 1'b0) begin
        startCycle = cycleCount;
        repeat (BAUD_DIV / 2) @(negedge clk);
        frame[0] = tx;
        for (int k = 1; k < 10; k++) begin
          repeat (BAUD_DIV) @(negedge clk);
          frame[k] = tx;
        end
        if (!ignoreRx) begin
          if (expByteQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rxUnexpected: got byte 0x%0h, expected none", frame[8:1]);
          end else begin
            e = expByteQ.pop_front();
            checkOutput("rxData", 32'(frame[8:1]), 32'(e.data));
            checkOutput("rxFraming", 32'({frame[9], frame[0]}), 32'b10);
            if (e.gapKind == 2'd1) begin
              checkOutput("rxBackToBack", 32'(startCycle - lastStart), FRAME_CYCLES);
            end else if (e.gapKind == 2'd2) begin
              checkOutput("rxWordGapOk", 32'((startCycle - lastStart) >= int'(FRAME_CYCLES + 2)), 32'd1);
            end
          end
        end
        lastStart = startCycle;
      end
      prevTx = tx;
    end
  end

  // Build expectations from the RAM image, issue the dump and wait for done.
  task automatic applyStimulus(input int unsigned addr, input int unsigned cnt,
                               input int stallCycles, input bit midStart);
    logic [7:0]  csum;
    logic [7:0]  b;
    logic [1:0]  g;
    logic [31:0] w;
    int unsigned a;
    int          doneBefore;
    int          waited;
    int          limit;
    bit          seenDone;
    bit          txLowInStall;
    csum = 8'h00;
    for (int i = 0; i < int'(cnt); i++) begin
      a = (addr + i) % RAM_DEPTH;
      expAddrQ.push_back(a);
      w = memModel[a];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        csum ^= b;
        g = (k != 0) ? 2'd1 : ((i == 0) ? 2'd0 : 2'd2);
        expByteQ.push_back({b, g});
      end
    end
    if (cnt > 0) expByteQ.push_back({csum, 2'd1});

    gnt = (stallCycles == 0);
    @(posedge clk); #1;
    start     = 1'b1;
    startAddr = AW'(addr);
    wordCnt   = (AW+1)'(cnt);
    doneBefore = doneCount;
    @(posedge clk); #1;
    start     = 1'b0;
    startAddr = AW'($urandom);
    wordCnt   = (AW+1)'($urandom);

    limit        = stallCycles + 600 * int'(cnt) + 200;
    seenDone     = 1'b0;
    txLowInStall = 1'b0;
    waited       = 0;
    while (!seenDone && waited < limit) begin
      @(negedge clk);
      waited++;
      if (waited == 1) checkOutput("busyAfterStart", 32'(busy), 32'(cnt != 0));
      if (waited <= stallCycles && tx !== 1'b1) txLowInStall = 1'b1;
      if (waited == stallCycles) gnt = 1'b1;
      if (midStart && waited == 150) begin
        start     = 1'b1;
        startAddr = AW'(addr + 1234);
        wordCnt   = (AW+1)'(3);
      end
      if (midStart && waited == 151) start = 1'b0;
      if (done === 1'b1) seenDone = 1'b1;
    end
    checkOutput("doneSeen", 32'(seenDone), 32'd1);
    if (cnt == 0) checkOutput("zeroCntDoneLatency", 32'(waited <= 2), 32'd1);
    if (stallCycles > 0) checkOutput("txHighDuringStall", 32'(txLowInStall), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("donePulseCount", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("busyIdle", 32'(busy), 32'd0);
    checkOutput("txIdle", 32'(tx), 32'd1);
    checkOutput("bytesLeft", 32'(expByteQ.size()), 32'd0);
    checkOutput("addrsLeft", 32'(expAddrQ.size()), 32'd0);
    expByteQ.delete();
    expAddrQ.delete();
  endtask

  // Abort a dump with a one-cycle reset during a data bit of byte 0.
  task automatic resetMidFrame();
    memModel[100] = 32'h0000_0000;
    ignoreRx = 1'b1;
    gnt      = 1'b1;
    expAddrQ.push_back(100);
    @(posedge clk); #1;
    start     = 1'b1;
    startAddr = AW'(100);
    wordCnt   = (AW+1)'(2);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("preResetDataBit", 32'(tx), 32'd0);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("rstTxHigh", 32'(tx), 32'd1);
    checkOutput("rstBusyLow", 32'(busy), 32'd0);
    checkOutput("rstRdEnLow", 32'(rdEn), 32'd0);
    rstN = 1'b1;
    repeat (120) @(negedge clk);
    expByteQ.delete();
    expAddrQ.delete();
    ignoreRx = 1'b0;
  endtask

  initial begin : watchdog
    #900_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int unsigned a;
    for (int i = 0; i < int'(RAM_DEPTH); i++) memModel[i] = $urandom;
    rstN      = 1'b0;
    start     = 1'b0;
    startAddr = '0;
    wordCnt   = '0;
    gnt       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetTx", 32'(tx), 32'd1);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetRdEn", 32'(rdEn), 32'd0);
    checkOutput("resetAddr", 32'(memAddr), 32'd0);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] single word");
    memModel[5] = 32'h1122_3344;
    applyStimulus(5, 1, 0, 1'b0);

    $display("[TB] zero count");
    applyStimulus(7, 0, 0, 1'b0);

    $display("[TB] address wrap");
    memModel[RAM_DEPTH-1] = 32'hAABB_CCDD;
    memModel[0]           = 32'h0102_0304;
    applyStimulus(RAM_DEPTH - 1, 2, 0, 1'b0);

    $display("[TB] grant stall");
    applyStimulus(200, 1, 50, 1'b0);

    $display("[TB] start ignored mid-dump");
    applyStimulus(300, 2, 0, 1'b1);

    $display("[TB] reset mid-frame then clean dump");
    resetMidFrame();
    memModel[101] = $urandom;
    applyStimulus(100, 2, 0, 1'b0);

    $display("[TB] random dumps");
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) a = RAM_DEPTH - 1 - $urandom_range(0, 3);
      else            a = $urandom_range(0, RAM_DEPTH - 1);
      applyStimulus(a, $urandom_range(1, 3),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
